// File: rtl/ro_puf_eval.sv
`default_nettype none
// ============================================================================
// Module      : ro_puf_eval
// Description : Ring-oscillator PUF evaluator. Counts edges of one selected
//               oscillator per bank over a window and compares the counts.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_puf_eval #(
    parameter int N_RO       = 32,
    parameter int SEL_W      = 4,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*SEL_W-1:0] challenge,
    input  logic [WIN_W-1:0]   win_len,
    input  logic [N_RO-1:0]    ro_in,
    output logic [N_RO-1:0]    ro_en,
    output logic               busy,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp,
    output logic               resp_tie,
    output logic               resp_sat,
    output logic [CNT_W-1:0]   cnt_a,
    output logic [CNT_W-1:0]   cnt_b
);

    localparam int c_HALF  = N_RO / 2;
    localparam int c_SET_W = $clog2(SETTLE_CYC + 1);

    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;
    localparam logic [c_HALF-1:0] c_ONE     = {{(c_HALF-1){1'b0}}, 1'b1};

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SETTLE  = 3'd1;
    localparam logic [2:0] c_ST_COUNT   = 3'd2;
    localparam logic [2:0] c_ST_COMPARE = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [SEL_W-1:0]   r_sel_a;
    logic [SEL_W-1:0]   r_sel_b;
    logic [WIN_W-1:0]   r_win;
    logic [WIN_W-1:0]   r_left;
    logic [c_SET_W-1:0] r_settle;
    logic [N_RO-1:0]    r_sync1;
    logic [N_RO-1:0]    r_sync2;
    logic [N_RO-1:0]    r_prev;
    logic [CNT_W-1:0]   r_cnt_a;
    logic [CNT_W-1:0]   r_cnt_b;
    logic               r_sat_a;
    logic               r_sat_b;
    logic               r_resp;
    logic               r_tie;

    logic [N_RO-1:0]    w_rise;
    logic [c_HALF-1:0]  w_rise_lo;
    logic [c_HALF-1:0]  w_rise_hi;
    logic               w_rise_a;
    logic               w_rise_b;
    logic               w_counting;
    logic               w_en;

    assign w_rise     = r_sync2 & ~r_prev;
    assign w_rise_lo  = w_rise[c_HALF-1:0];
    assign w_rise_hi  = w_rise[N_RO-1:c_HALF];
    assign w_rise_a   = w_rise_lo[r_sel_a];
    assign w_rise_b   = w_rise_hi[r_sel_b];
    assign w_counting = (r_state == c_ST_COUNT);
    assign w_en       = (r_state == c_ST_SETTLE) || w_counting;

    assign ro_en      = w_en ? {c_ONE << r_sel_b, c_ONE << r_sel_a} : '0;
    assign busy       = (r_state != c_ST_IDLE);
    assign resp_valid = (r_state == c_ST_DONE);
    assign resp       = r_resp;
    assign resp_tie   = r_tie;
    assign resp_sat   = r_sat_a | r_sat_b;
    assign cnt_a      = r_cnt_a;
    assign cnt_b      = r_cnt_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // SETTLE runs SETTLE_CYC+1 cycles: the enable-launch cycle plus the settle time.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (start) w_state_nxt = c_ST_SETTLE;
            c_ST_SETTLE:  if (r_settle == '0) w_state_nxt = c_ST_COUNT;
            c_ST_COUNT:   if (r_left == WIN_W'(1)) w_state_nxt = c_ST_COMPARE;
            c_ST_COMPARE: w_state_nxt = c_ST_DONE;
            c_ST_DONE:    if (resp_ready) w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_sel_a  <= '0;
            r_sel_b  <= '0;
            r_win    <= '0;
            r_left   <= '0;
            r_settle <= '0;
            r_cnt_a  <= '0;
            r_cnt_b  <= '0;
            r_sat_a  <= 1'b0;
            r_sat_b  <= 1'b0;
            r_resp   <= 1'b0;
            r_tie    <= 1'b0;
        end else begin
            r_sync1 <= ro_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;

            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_sel_a  <= challenge[SEL_W-1:0];
                        r_sel_b  <= challenge[2*SEL_W-1:SEL_W];
                        r_win    <= (win_len == '0) ? WIN_W'(1) : win_len;
                        r_settle <= c_SET_W'(SETTLE_CYC);
                        r_cnt_a  <= '0;
                        r_cnt_b  <= '0;
                        r_sat_a  <= 1'b0;
                        r_sat_b  <= 1'b0;
                        r_resp   <= 1'b0;
                        r_tie    <= 1'b0;
                    end
                end
                c_ST_SETTLE: begin
                    if (r_settle == '0) begin
                        r_left <= r_win;
                    end else begin
                        r_settle <= r_settle - c_SET_W'(1);
                    end
                end
                c_ST_COUNT: begin
                    r_left <= r_left - WIN_W'(1);
                    // Saturating counters; the sticky flag marks the step onto the maximum.
                    if (w_rise_a && (r_cnt_a != c_CNT_MAX)) begin
                        r_cnt_a <= r_cnt_a + CNT_W'(1);
                        if (r_cnt_a == c_CNT_MAX - CNT_W'(1)) r_sat_a <= 1'b1;
                    end
                    if (w_rise_b && (r_cnt_b != c_CNT_MAX)) begin
                        r_cnt_b <= r_cnt_b + CNT_W'(1);
                        if (r_cnt_b == c_CNT_MAX - CNT_W'(1)) r_sat_b <= 1'b1;
                    end
                end
                c_ST_COMPARE: begin
                    r_resp <= (r_cnt_b >= r_cnt_a);
                    r_tie  <= (r_cnt_b == r_cnt_a);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_eval.sv
`default_nettype none
// Testbench for ro_puf_eval: directed scenarios plus randomized challenges
// checked against period-based edge-count expectations.
module tb_ro_puf_eval;

    localparam int N_RO = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        challenge = '0;
    logic [15:0]       win_len = '0;
    logic [N_RO-1:0]   ro_in = '0;
    logic              resp_ready = 1'b0;

    logic [N_RO-1:0]   ro_en;
    logic              busy, resp_valid, resp, resp_tie, resp_sat;
    logic [15:0]       cnt_a, cnt_b;

    logic [N_RO-1:0]   s_ro_en;
    logic              s_busy, s_resp_valid, s_resp, s_resp_tie, s_resp_sat;
    logic [3:0]        s_cnt_a, s_cnt_b;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int period [N_RO];
    int phase  [N_RO];

    ro_puf_eval dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .win_len(win_len), .ro_in(ro_in), .ro_en(ro_en), .busy(busy),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp(resp),
        .resp_tie(resp_tie), .resp_sat(resp_sat), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    ro_puf_eval #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .win_len(win_len), .ro_in(ro_in), .ro_en(s_ro_en), .busy(s_busy),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp(s_resp),
        .resp_tie(s_resp_tie), .resp_sat(s_resp_sat), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
    );

    always #5 clk = ~clk;

    // Square-wave oscillator sources, high for the first half of each period.
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < N_RO; i++) begin
            if (period[i] == 0) ro_in[i] = 1'b0;
            else ro_in[i] = (((cyc + phase[i]) % period[i]) < (period[i] / 2));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_osc();
        for (int i = 0; i < N_RO; i++) begin
            period[i] = 0;
            phase[i]  = 0;
        end
    endtask

    task automatic run_eval(input logic [7:0] ch, input logic [15:0] wl,
                            output int lat, output logic [N_RO-1:0] en_snap);
        @(negedge clk);
        challenge = ch;
        win_len   = wl;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        lat     = 0;
        en_snap = '0;
        while (lat < 5000) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 3) en_snap = ro_en;
            if (resp_valid === 1'b1) break;
        end
    endtask

    task automatic release_resp(output logic v, output logic b);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        v = resp_valid;
        b = busy;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        clear_osc();
        period[10] = 8;
        period[19] = 6;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, resp_valid, resp, resp_tie, resp_sat} !== 5'b0) $display("FAIL reset_flags: got %b, expected 00000", {busy, resp_valid, resp, resp_tie, resp_sat});
        else pass_cnt++;
        total_cnt++;
        if (ro_en !== '0) $display("FAIL reset_ro_en: got %h, expected 0", ro_en);
        else pass_cnt++;
        total_cnt++;
        if (cnt_a !== 16'd0 || cnt_b !== 16'd0) $display("FAIL reset_counts: got %0d/%0d, expected 0/0", cnt_a, cnt_b);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b, expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int lat;
        logic [N_RO-1:0] en;
        logic ok, v, b;
        clear_osc();
        period[10] = 8;
        period[19] = 6;
        run_eval(8'h3A, 16'd96, lat, en);
        total_cnt++;
        if (lat !== 102) $display("FAIL basic_latency: got %0d, expected 102", lat);
        else pass_cnt++;
        total_cnt++;
        if (en !== 32'h0008_0400) $display("FAIL basic_ro_en: got %h, expected 00080400", en);
        else pass_cnt++;
        ok = (cnt_a >= 16'd11) && (cnt_a <= 16'd12);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL basic_cnt_a: got %0d, expected 11..12", cnt_a);
        else pass_cnt++;
        ok = (cnt_b >= 16'd15) && (cnt_b <= 16'd17);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL basic_cnt_b: got %0d, expected 15..17", cnt_b);
        else pass_cnt++;
        total_cnt++;
        if ({resp, resp_tie, resp_sat} !== 3'b100) $display("FAIL basic_resp: got resp/tie/sat=%b, expected 100", {resp, resp_tie, resp_sat});
        else pass_cnt++;
        total_cnt++;
        if (ro_en !== '0) $display("FAIL done_ro_en: got %h, expected 0", ro_en);
        else pass_cnt++;
        release_resp(v, b);
        total_cnt++;
        if ({v, b} !== 2'b00) $display("FAIL basic_release: valid/busy=%b, expected 00", {v, b});
        else pass_cnt++;
    endtask

    task automatic test_swap();
        int lat;
        logic [N_RO-1:0] en;
        logic v, b;
        clear_osc();
        period[10] = 6;
        period[19] = 8;
        run_eval(8'h3A, 16'd96, lat, en);
        total_cnt++;
        if ({resp_valid, resp, resp_tie} !== 3'b100) $display("FAIL swap_resp: got valid/resp/tie=%b, expected 100", {resp_valid, resp, resp_tie});
        else pass_cnt++;
        release_resp(v, b);
    endtask

    task automatic test_tie();
        int lat;
        logic [N_RO-1:0] en;
        logic v, b;
        clear_osc();
        period[10] = 10;
        period[19] = 10;
        run_eval(8'h3A, 16'd100, lat, en);
        total_cnt++;
        if (cnt_a !== 16'd10 || cnt_b !== 16'd10) $display("FAIL tie_counts: got %0d/%0d, expected 10/10", cnt_a, cnt_b);
        else pass_cnt++;
        total_cnt++;
        if ({resp, resp_tie} !== 2'b11) $display("FAIL tie_resp: got resp/tie=%b, expected 11", {resp, resp_tie});
        else pass_cnt++;
        release_resp(v, b);
    endtask

    task automatic test_saturation();
        int lat;
        logic [N_RO-1:0] en;
        logic v, b;
        clear_osc();
        period[10] = 4;
        period[19] = 4;
        run_eval(8'h3A, 16'd200, lat, en);
        total_cnt++;
        if (s_cnt_a !== 4'd15 || s_cnt_b !== 4'd15) $display("FAIL sat_counts: got %0d/%0d, expected 15/15", s_cnt_a, s_cnt_b);
        else pass_cnt++;
        total_cnt++;
        if ({s_resp_valid, s_resp_sat, s_resp_tie} !== 3'b111) $display("FAIL sat_flags: got valid/sat/tie=%b, expected 111", {s_resp_valid, s_resp_sat, s_resp_tie});
        else pass_cnt++;
        total_cnt++;
        if (cnt_a !== 16'd50 || resp_sat !== 1'b0) $display("FAIL wide_no_sat: got cnt_a=%0d sat=%b, expected 50 0", cnt_a, resp_sat);
        else pass_cnt++;
        release_resp(v, b);
    endtask

    task automatic test_reset_mid_count();
        int lat;
        logic [N_RO-1:0] en;
        logic seen, v, b;
        clear_osc();
        period[10] = 8;
        period[19] = 6;
        @(negedge clk);
        challenge = 8'h3A;
        win_len   = 16'd96;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (44) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b0 || ro_en !== '0 || cnt_a !== 16'd0 || cnt_b !== 16'd0 || resp_valid !== 1'b0)
            $display("FAIL abort_state: busy=%b ro_en=%h cnt=%0d/%0d valid=%b, expected all 0", busy, ro_en, cnt_a, cnt_b, resp_valid);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL abort_no_valid: resp_valid seen=%b, expected 0", seen);
        else pass_cnt++;
        run_eval(8'h3A, 16'd96, lat, en);
        total_cnt++;
        if (lat !== 102 || resp !== 1'b1) $display("FAIL abort_rerun: latency=%0d resp=%b, expected 102 1", lat, resp);
        else pass_cnt++;
        release_resp(v, b);
    endtask

    task automatic test_start_during_count();
        int n;
        int unstable;
        logic en_bad;
        logic [34:0] snap;
        logic ok;
        clear_osc();
        period[10] = 8;
        period[19] = 6;
        period[12] = 6;
        period[21] = 8;
        @(negedge clk);
        challenge = 8'h3A;
        win_len   = 16'd96;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        n      = 0;
        en_bad = 1'b0;
        while (n < 500) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 30) begin
                challenge = 8'h5C;
                win_len   = 16'd10;
                start     = 1'b1;
            end
            if (n == 31) start = 1'b0;
            if (ro_en !== '0 && ro_en !== 32'h0008_0400) en_bad = 1'b1;
            if (resp_valid === 1'b1) break;
        end
        total_cnt++;
        if (n !== 102 || en_bad !== 1'b0) $display("FAIL midstart_ignored: latency=%0d en_bad=%b, expected 102 0", n, en_bad);
        else pass_cnt++;
        ok = (resp === 1'b1) && (cnt_a >= 16'd11) && (cnt_a <= 16'd12) && (cnt_b >= 16'd15) && (cnt_b <= 16'd17);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL midstart_result: resp=%b cnt=%0d/%0d, expected 1 11..12/15..17", resp, cnt_a, cnt_b);
        else pass_cnt++;
        snap = {resp, resp_tie, resp_sat, cnt_a, cnt_b};
        unstable = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b1 || {resp, resp_tie, resp_sat, cnt_a, cnt_b} !== snap) unstable++;
        end
        total_cnt++;
        if (unstable !== 0) $display("FAIL hold_stable: %0d unstable cycles, expected 0", unstable);
        else pass_cnt++;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({resp_valid, busy} !== 2'b00) $display("FAIL hold_release: valid/busy=%b, expected 00", {resp_valid, busy});
        else pass_cnt++;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        int n;
        logic [N_RO-1:0] en;
        logic v, b;
        clear_osc();
        period[10] = 8;
        period[19] = 6;
        run_eval(8'h3A, 16'd20, lat, en);
        total_cnt++;
        if (lat !== 26) $display("FAIL b2b_first_latency: got %0d, expected 26", lat);
        else pass_cnt++;
        @(negedge clk);
        start      = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL b2b_done_start_ignored: busy=%b, expected 0", busy);
        else pass_cnt++;
        @(negedge clk);
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%b, expected 1", busy);
        else pass_cnt++;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < 500) begin
            @(posedge clk);
            #1;
            n++;
            if (resp_valid === 1'b1) break;
        end
        total_cnt++;
        if (n !== 26) $display("FAIL b2b_second_latency: got %0d, expected 26", n);
        else pass_cnt++;
        release_resp(v, b);
    endtask

    task automatic test_win_zero();
        int lat;
        logic [N_RO-1:0] en;
        logic v, b;
        clear_osc();
        period[10] = 4;
        run_eval(8'h3A, 16'd0, lat, en);
        total_cnt++;
        if (lat !== 7) $display("FAIL win_zero_latency: got %0d, expected 7", lat);
        else pass_cnt++;
        release_resp(v, b);
    endtask

    task automatic test_random();
        int lat, sa, sb, pa, pb, wl;
        int lo_a, hi_a, lo_b, hi_b;
        logic [N_RO-1:0] en, exp_en;
        logic ok, v, b;
        for (int it = 0; it < 5; it++) begin
            sa = $urandom_range(15, 0);
            sb = $urandom_range(15, 0);
            pa = $urandom_range(20, 6);
            pb = $urandom_range(20, 6);
            wl = $urandom_range(160, 40);
            for (int i = 0; i < N_RO; i++) begin
                period[i] = 3;
                phase[i]  = $urandom_range(2, 0);
            end
            period[sa]      = pa;
            phase[sa]       = $urandom_range(pa - 1, 0);
            period[16 + sb] = pb;
            phase[16 + sb]  = $urandom_range(pb - 1, 0);
            // A window of wl cycles over a period-P square wave holds floor or ceil of wl/P rising edges.
            lo_a = wl / pa;
            hi_a = (wl + pa - 1) / pa;
            lo_b = wl / pb;
            hi_b = (wl + pb - 1) / pb;
            exp_en = (32'd1 << sa) | (32'd1 << (16 + sb));
            run_eval({sb[3:0], sa[3:0]}, wl[15:0], lat, en);
            ok = (lat == wl + 6) && (en === exp_en);
            total_cnt++;
            if (ok !== 1'b1) $display("FAIL rand%0d_timing: latency=%0d ro_en=%h, expected %0d %h", it, lat, en, wl + 6, exp_en);
            else pass_cnt++;
            ok = (int'(cnt_a) >= lo_a) && (int'(cnt_a) <= hi_a) && (int'(cnt_b) >= lo_b) && (int'(cnt_b) <= hi_b);
            total_cnt++;
            if (ok !== 1'b1) $display("FAIL rand%0d_counts: got %0d/%0d, expected %0d..%0d/%0d..%0d", it, cnt_a, cnt_b, lo_a, hi_a, lo_b, hi_b);
            else pass_cnt++;
            ok = (resp === (cnt_b >= cnt_a)) && (resp_tie === (cnt_b == cnt_a)) && (resp_sat === 1'b0);
            total_cnt++;
            if (ok !== 1'b1) $display("FAIL rand%0d_resp: resp/tie/sat=%b for counts %0d/%0d", it, {resp, resp_tie, resp_sat}, cnt_a, cnt_b);
            else pass_cnt++;
            release_resp(v, b);
        end
    endtask

    initial begin
        clear_osc();
        test_reset();
        test_basic();
        test_swap();
        test_tie();
        test_saturation();
        test_reset_mid_count();
        test_start_during_count();
        test_back_to_back();
        test_win_zero();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
